// File: rtl/tier2_pkg.sv
// Shared types and defaults for the tier-2 packet scheduler.
package tier2_pkg;
  localparam int DEF_LAYER_W = 4;
  localparam int DEF_RES_W   = 3;
  localparam int DEF_CB_W    = 6;
  localparam int DEF_PKT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SOP, ST_HDR_REQ, ST_BODY_REQ, ST_NEXT, ST_DONE
  } state_e;

  // Only LRCP is walked today; RLCP reuses the same counters in a different nest order.
  typedef enum logic [1:0] {PROG_LRCP = 2'd0, PROG_RLCP = 2'd1} prog_e;
  localparam prog_e PROG_ORDER = PROG_LRCP;
endpackage

// File: rtl/tier2_req_ack.sv
// One level req/ack channel: raised on entry, dropped on ack or abort.
module tier2_req_ack (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic set,
  input  logic clr,
  output logic req
);
  // set beats clr so back-to-back body blocks keep req high without a gap
  always_ff @(posedge clk or negedge rst)
    if (!rst)       req <= 1'b0;
    else if (abort) req <= 1'b0;
    else if (set)   req <= 1'b1;
    else if (clr)   req <= 1'b0;
endmodule

// File: rtl/tier2_packet_scheduler.sv
// LRCP packet walker driving header/body emitters over req/ack.
// Optional SOP marker handshake before every header: define SOP_MARKER_EN.
module tier2_packet_scheduler
  import tier2_pkg::*;
#(
  parameter int LAYER_W = DEF_LAYER_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int CB_W    = DEF_CB_W,
  parameter int PKT_W   = DEF_PKT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_syn,
  input  logic               codestream_generate_start,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic [RES_W-1:0]   num_res,
  input  logic [CB_W-1:0]    cb_num_in,
  output logic               hdr_req,
  input  logic               hdr_ack,
  output logic               body_req,
  input  logic               body_ack,
`ifdef SOP_MARKER_EN
  output logic               sop_req,
  input  logic               sop_ack,
`endif
  output logic [LAYER_W-1:0] layer_idx,
  output logic [RES_W-1:0]   res_idx,
  output logic [CB_W-1:0]    cb_idx,
  output logic [PKT_W-1:0]   pkt_seq,
  output logic               busy,
  output logic               codestream_generate_over
);
  state_e state, state_nxt;
  logic [LAYER_W-1:0] nlay;
  logic [RES_W-1:0]   nres;
  logic hdr_fire, body_fire, hdr_set, body_set;
  logic cb_last, res_last, lay_last, cnt_zero;

`ifdef SOP_MARKER_EN
  localparam state_e ST_PKT = ST_SOP;
  logic sop_fire, sop_set;
  assign sop_fire = sop_req & sop_ack;
`else
  localparam state_e ST_PKT = ST_HDR_REQ;
`endif

  assign hdr_fire  = hdr_req & hdr_ack;
  assign body_fire = body_req & body_ack;
  // one extra bit so count-1 compares never wrap
  assign cb_last  = ({1'b0, cb_idx} + (CB_W+1)'(1)) == {1'b0, cb_num_in};
  assign res_last = ({1'b0, res_idx} + (RES_W+1)'(1)) == {1'b0, nres};
  assign lay_last = ({1'b0, layer_idx} + (LAYER_W+1)'(1)) == {1'b0, nlay};
  assign cnt_zero = (nlay == '0) || (nres == '0);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (rst_syn) state_nxt = ST_IDLE;
    else case (state)
      ST_IDLE:     if (codestream_generate_start) state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = cnt_zero ? ST_DONE : ST_PKT;
`ifdef SOP_MARKER_EN
      ST_SOP:      if (sop_fire) state_nxt = ST_HDR_REQ;
`endif
      ST_HDR_REQ:  if (hdr_fire) state_nxt = (cb_num_in == '0) ? ST_NEXT : ST_BODY_REQ;
      ST_BODY_REQ: if (body_fire && cb_last) state_nxt = ST_NEXT;
      ST_NEXT:     state_nxt = (res_last && lay_last) ? ST_DONE : ST_PKT;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_set  = 1'b0;
    body_set = 1'b0;
`ifdef SOP_MARKER_EN
    sop_set  = 1'b0;
`endif
    case (state_nxt)
      ST_HDR_REQ:  hdr_set  = (state != ST_HDR_REQ);
      ST_BODY_REQ: body_set = (state != ST_BODY_REQ) || body_fire;
`ifdef SOP_MARKER_EN
      ST_SOP:      sop_set  = (state != ST_SOP);
`endif
      default: ;
    endcase
  end

  tier2_req_ack u_hdr  (.clk, .rst, .abort(rst_syn), .set(hdr_set),  .clr(hdr_fire),  .req(hdr_req));
  tier2_req_ack u_body (.clk, .rst, .abort(rst_syn), .set(body_set), .clr(body_fire), .req(body_req));
`ifdef SOP_MARKER_EN
  tier2_req_ack u_sop  (.clk, .rst, .abort(rst_syn), .set(sop_set),  .clr(sop_fire),  .req(sop_req));
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      nlay <= '0; nres <= '0;
      layer_idx <= '0; res_idx <= '0; cb_idx <= '0; pkt_seq <= '0;
      busy <= 1'b0; codestream_generate_over <= 1'b0;
    end else if (rst_syn) begin
      layer_idx <= '0; res_idx <= '0; cb_idx <= '0; pkt_seq <= '0;
      busy <= 1'b0; codestream_generate_over <= 1'b0;
    end else begin
      codestream_generate_over <= (state == ST_DONE);
      case (state)
        ST_IDLE: if (codestream_generate_start) begin
          nlay <= num_layers; nres <= num_res;
          layer_idx <= '0; res_idx <= '0; cb_idx <= '0; pkt_seq <= '0;
          busy <= 1'b1;
        end
        ST_HDR_REQ:  if (hdr_fire) cb_idx <= '0;
        ST_BODY_REQ: if (body_fire && !cb_last) cb_idx <= cb_idx + 1'b1;
        ST_NEXT: begin
          pkt_seq <= pkt_seq + 1'b1;
          // the final packet leaves the indices on the last layer/resolution
          if (!(res_last && lay_last)) begin
            if (res_last) begin
              res_idx   <= '0;
              layer_idx <= layer_idx + 1'b1;
            end else res_idx <= res_idx + 1'b1;
          end
        end
        ST_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tier2_packet_scheduler.sv
// Bench for tier2_packet_scheduler: table jobs, random jobs vs an LRCP event model, hand corner cases.
module tb_tier2_packet_scheduler;
  localparam int LAYER_W = 4, RES_W = 3, CB_W = 6, PKT_W = 16;

  logic clk = 1'b0, rst = 1'b0, rst_syn = 1'b0, codestream_generate_start = 1'b0;
  logic [LAYER_W-1:0] num_layers = '0;
  logic [RES_W-1:0]   num_res = '0;
  logic [CB_W-1:0]    cb_num_in;
  logic hdr_req, body_req, busy, codestream_generate_over;
  logic hdr_ack = 1'b0, body_ack = 1'b0;
  logic [LAYER_W-1:0] layer_idx;
  logic [RES_W-1:0]   res_idx;
  logic [CB_W-1:0]    cb_idx;
  logic [PKT_W-1:0]   pkt_seq;
`ifdef SOP_MARKER_EN
  logic sop_req;
  logic sop_ack = 1'b0;
`endif

  int cb_tab [8];
  int checks = 0, errors = 0;

  assign cb_num_in = CB_W'(cb_tab[res_idx]);
  always #5 clk = ~clk;

  tier2_packet_scheduler #(.LAYER_W(LAYER_W), .RES_W(RES_W), .CB_W(CB_W), .PKT_W(PKT_W)) dut (
    .clk(clk), .rst(rst), .rst_syn(rst_syn),
    .codestream_generate_start(codestream_generate_start),
    .num_layers(num_layers), .num_res(num_res), .cb_num_in(cb_num_in),
    .hdr_req(hdr_req), .hdr_ack(hdr_ack), .body_req(body_req), .body_ack(body_ack),
`ifdef SOP_MARKER_EN
    .sop_req(sop_req), .sop_ack(sop_ack),
`endif
    .layer_idx(layer_idx), .res_idx(res_idx), .cb_idx(cb_idx), .pkt_seq(pkt_seq),
    .busy(busy), .codestream_generate_over(codestream_generate_over)
  );

  typedef struct {
    int L; int R; int cb[4]; int maxd; int exp_hdr; int exp_body; int exp_pkt;
  } vec_t;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // kind: 1 header, 2 body, 3 sop
  function automatic logic [47:0] ev(input int k, input int l, input int r, input int c, input int p);
    return {8'(k), 8'(l), 8'(r), 8'(c), 16'(p)};
  endfunction

  task automatic run_job(input int L, input int R, input int maxd, input bit stray,
                         output int nh, output int nb);
    logic [47:0] exp_q[$], obs_q[$];
    int p = 0, dly, cycles = 0, overs = 0, n;
    bit acked = 1'b0;
    nh = 0; nb = 0;
    for (int l = 0; l < L; l++)
      for (int r = 0; r < R; r++) begin
`ifdef SOP_MARKER_EN
        exp_q.push_back(ev(3, l, r, 0, p));
`endif
        exp_q.push_back(ev(1, l, r, 0, p));
        for (int c = 0; c < cb_tab[r]; c++) exp_q.push_back(ev(2, l, r, c, p));
        p++;
      end
    @(negedge clk);
    num_layers = LAYER_W'(L); num_res = RES_W'(R); codestream_generate_start = 1'b1;
    dly = $urandom_range(maxd, 0);
    while (overs == 0 && cycles < 4000) begin
      @(negedge clk);
      codestream_generate_start = 1'b0; hdr_ack = 1'b0; body_ack = 1'b0;
`ifdef SOP_MARKER_EN
      sop_ack = 1'b0;
`endif
      cycles++;
      if (codestream_generate_over) overs++;
      if (acked) begin
        acked = 1'b0; dly = $urandom_range(maxd, 0);
      end
`ifdef SOP_MARKER_EN
      else if (sop_req) begin
        if (dly == 0) begin sop_ack = 1'b1; acked = 1'b1; obs_q.push_back(ev(3, layer_idx, res_idx, 0, pkt_seq)); end
        else dly--;
      end
`endif
      else if (hdr_req) begin
        if (dly == 0) begin hdr_ack = 1'b1; acked = 1'b1; nh++; obs_q.push_back(ev(1, layer_idx, res_idx, 0, pkt_seq)); end
        else dly--;
      end else if (body_req) begin
        if (dly == 0) begin body_ack = 1'b1; acked = 1'b1; nb++; obs_q.push_back(ev(2, layer_idx, res_idx, cb_idx, pkt_seq)); end
        else begin
          dly--;
          if (stray) begin  // stray header ack and a restart attempt mid-body must change nothing
            hdr_ack = 1'b1; codestream_generate_start = 1'b1;
            num_layers = LAYER_W'($urandom); num_res = RES_W'($urandom);
          end
        end
      end
    end
    if (overs == 0) begin
      errors++; checks++;
      $display("FAIL job_timeout: got no over pulse expected one (L=%0d R=%0d)", L, R);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (codestream_generate_over) overs++;
    end
    check("over_pulses", 48'(overs), 48'd1);
    check("busy_after", 48'(busy), 48'd0);
    check("pkt_seq_final", 48'(pkt_seq), 48'(p));
    check("event_count", 48'(obs_q.size()), 48'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("event", obs_q[i], exp_q[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int nh, nb;
    tbl[0] = '{1, 1, '{3, 0, 0, 0}, 2, 1, 3, 1};
    tbl[1] = '{2, 3, '{0, 2, 1, 0}, 1, 6, 6, 6};
    tbl[2] = '{0, 2, '{1, 1, 0, 0}, 1, 0, 0, 0};
    tbl[3] = '{3, 0, '{1, 1, 0, 0}, 1, 0, 0, 0};
    tbl[4] = '{2, 2, '{1, 0, 0, 0}, 0, 4, 2, 4};
    tbl[5] = '{1, 4, '{2, 1, 0, 3}, 3, 4, 6, 4};
    for (int i = 0; i < 8; i++) cb_tab[i] = 0;

    repeat (2) @(negedge clk);
    check("reset_outs", {hdr_req, body_req, busy, codestream_generate_over, 8'(layer_idx), 8'(res_idx), 8'(cb_idx)}, '0);
    check("reset_pkt", 48'(pkt_seq), 48'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 4; r++) cb_tab[r] = tbl[i].cb[r];
      run_job(tbl[i].L, tbl[i].R, tbl[i].maxd, i == 5, nh, nb);
      check("tbl_hdr", 48'(nh), 48'(tbl[i].exp_hdr));
      check("tbl_body", 48'(nb), 48'(tbl[i].exp_body));
      check("tbl_pkt", 48'(pkt_seq), 48'(tbl[i].exp_pkt));
    end

    // zero-count job: busy two cycles, over on the third
    @(negedge clk); num_layers = 0; num_res = 3; codestream_generate_start = 1'b1;
    @(negedge clk); codestream_generate_start = 1'b0;
    check("zero_c1", {busy, codestream_generate_over, hdr_req, body_req}, 48'b1000);
    @(negedge clk); check("zero_c2", {busy, codestream_generate_over, hdr_req, body_req}, 48'b1000);
    @(negedge clk); check("zero_c3", {busy, codestream_generate_over, hdr_req, body_req}, 48'b0100);
    @(negedge clk); check("zero_c4", {busy, codestream_generate_over}, 48'b00);

`ifndef SOP_MARKER_EN
    // first-header latency, empty packet, then abort mid-body
    cb_tab[0] = 0;
    @(negedge clk); num_layers = 1; num_res = 1; codestream_generate_start = 1'b1;
    @(negedge clk); codestream_generate_start = 1'b0;
    check("lat_c1", {busy, hdr_req}, 48'b10);
    @(negedge clk); check("lat_c2", {busy, hdr_req}, 48'b11);
    hdr_ack = 1'b1;
    @(negedge clk); hdr_ack = 1'b0;
    check("empty_next", {hdr_req, body_req, busy, codestream_generate_over}, 48'b0010);
    @(negedge clk); check("empty_done", {busy, codestream_generate_over, 8'(pkt_seq)}, {2'b10, 8'd1});
    @(negedge clk); check("empty_over", {busy, codestream_generate_over}, 48'b01);

    cb_tab[0] = 3;
    @(negedge clk); num_layers = 1; num_res = 1; codestream_generate_start = 1'b1;
    @(negedge clk); codestream_generate_start = 1'b0;
    @(negedge clk); check("abort_hdr", 48'(hdr_req), 48'd1);
    hdr_ack = 1'b1;
    @(negedge clk); hdr_ack = 1'b0;
    check("abort_body0", {body_req, 8'(cb_idx)}, {1'b1, 8'd0});
    body_ack = 1'b1;
    @(negedge clk); body_ack = 1'b0;
    check("abort_body1", {body_req, 8'(cb_idx)}, {1'b1, 8'd1});
    rst_syn = 1'b1;
    @(negedge clk); rst_syn = 1'b0;
    check("abort_outs", {hdr_req, body_req, busy, codestream_generate_over, 8'(cb_idx), 8'(layer_idx), 8'(res_idx)}, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", {hdr_req, body_req, busy, codestream_generate_over}, '0);
    end
`endif

    // start and rst_syn together: start dropped
    @(negedge clk); num_layers = 1; num_res = 1; codestream_generate_start = 1'b1; rst_syn = 1'b1;
    @(negedge clk); codestream_generate_start = 1'b0; rst_syn = 1'b0;
    check("syn_wins_c1", {busy, hdr_req}, '0);
    @(negedge clk); @(negedge clk);
    check("syn_wins_c3", {busy, hdr_req, codestream_generate_over}, '0);

    cb_tab[0] = 3;
    run_job(1, 1, 1, 1'b0, nh, nb);
    check("clean_body", 48'(nb), 48'd3);

    for (int j = 0; j < 10; j++) begin
      for (int r = 0; r < 8; r++) cb_tab[r] = $urandom_range(3, 0);
      run_job($urandom_range(3, 0), $urandom_range(4, 0), $urandom_range(3, 0), 1'($urandom), nh, nb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
